// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op-code type and encodings.
// No ports; imported by alu_core, alu_pipe and the bench.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'b0000;
  localparam alu_op_t OP_SUB  = 4'b1000;
  localparam alu_op_t OP_AND  = 4'b0111;
  localparam alu_op_t OP_OR   = 4'b0110;
  localparam alu_op_t OP_XOR  = 4'b0100;
  localparam alu_op_t OP_SRL  = 4'b0101;
  localparam alu_op_t OP_SLL  = 4'b0001;
  localparam alu_op_t OP_SRA  = 4'b1101;
  localparam alu_op_t OP_SLT  = 4'b0010;
  localparam alu_op_t OP_SLTU = 4'b0011;

  // True for any op code the datapath implements.
  function automatic logic op_defined(input alu_op_t op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SRL, OP_SLL, OP_SRA, OP_SLT, OP_SLTU: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// Ports:
//   a, b    : operands (WIDTH)
//   op      : operation code (alu_op_t)
//   result  : operation result, 0 for undefined op codes
//   zero    : result == 0
//   err     : op code undefined
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // Only the low log2(WIDTH) bits of b form the shift amount.
  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  logic slt_s;
  logic slt_u;
  assign slt_s = $signed(a) < $signed(b);
  assign slt_u = a < b;

  // Result select; undefined codes yield zero with err raised.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> shamt;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_s};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, slt_u};
      default: begin
        result = '0;
        err    = ~op_defined(op);
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 holds operands, op and tag; S2 holds result, flags and tag.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : input handshake (in_ready_o is combinational)
//   in0_i, in1_i, op_i, tag_i: operation payload
//   out_valid_o / out_ready_i: output handshake
//   out_o, out_zero_o, out_err_o, out_tag_o : registered result payload
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [3:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             out_zero_o,
  output logic             out_err_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_t          s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_err;

  logic s2_load;
  logic in_fire;

  // S2 can take a new entry when empty or when its current entry leaves now.
  assign s2_load    = s1_valid && (!out_valid_o || out_ready_i);
  assign in_ready_o = !rst_i && (!s1_valid || s2_load);
  assign in_fire    = in_valid_i && in_ready_o;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .zero   (core_zero),
    .err    (core_err)
  );

  // Stage 1: operand register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_tag   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_a     <= in0_i;
        s1_b     <= in1_i;
        s1_op    <= op_i;
        s1_tag   <= tag_i;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result register; payload only changes on a load, so it holds under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_o       <= '0;
      out_zero_o  <= 1'b0;
      out_err_o   <= 1'b0;
      out_tag_o   <= '0;
    end else begin
      if (s2_load) begin
        out_valid_o <= 1'b1;
        out_o       <= core_result;
        out_zero_o  <= core_zero;
        out_err_o   <= core_err;
        out_tag_o   <= s1_tag;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
